// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and the rotating
// priority search for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requester agents
// and the round-robin arbiter.
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter8_decoder.sv
// Existing 3-to-8 one-hot decoder; a is the MSB.
// Drives the shared datapath select lines.
module decoder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);

  logic [2:0] sel;

  assign sel = {a, b, c};

  assign d0 = (sel == 3'd0);
  assign d1 = (sel == 3'd1);
  assign d2 = (sel == 3'd2);
  assign d3 = (sel == 3'd3);
  assign d4 = (sel == 3'd4);
  assign d5 = (sel == 3'd5);
  assign d6 = (sel == 3'd6);
  assign d7 = (sel == 3'd7);

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters, bounded hold time,
// one IDLE bubble between grants.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  bus
);

  localparam int CW = $clog2(HOLD_MAX);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  cnt_t             hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic             rel_norm, rel_force;
  logic [N_REQ-1:0] dec;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    rel_norm    = 1'b0;
    rel_force   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_idx_d   = rr_pick(bus.req, ptr_q);
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // done/withdraw outrank the limit, so no timeout then
        rel_norm  = bus.done || !bus.req[gnt_idx_q];
        rel_force = (hold_cnt_q == HOLD_LAST);
        if (rel_norm || rel_force) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          timeout_d   = !rel_norm;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  decoder u_dec (
    .a  (gnt_idx_q[2]),
    .b  (gnt_idx_q[1]),
    .c  (gnt_idx_q[0]),
    .d0 (dec[0]),
    .d1 (dec[1]),
    .d2 (dec[2]),
    .d3 (dec[3]),
    .d4 (dec[4]),
    .d5 (dec[5]),
    .d6 (dec[6]),
    .d7 (dec[7])
  );

  assign bus.gnt       = gnt_valid_q ? dec : '0;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed-vector bench for rr_arbiter8 (HOLD_MAX=4)
// with a queue scoreboard checked at the falling edge.
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  typedef struct packed {
    logic       v;
    logic [7:0] g;
    logic [2:0] i;
    logic       t;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic       done;
    obs_t       want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(
    .HOLD_MAX (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t vecs[$];
  obs_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   n_mon  = 0;
  obs_t got;
  obs_t want;

  task automatic add(
    input logic       r,
    input logic [7:0] q,
    input logic       d,
    input logic       v,
    input logic [7:0] g,
    input logic [2:0] i,
    input logic       t
  );
    vec_t x;
    x.rst    = r;
    x.req    = q;
    x.done   = d;
    x.want.v = v;
    x.want.g = g;
    x.want.i = i;
    x.want.t = t;
    vecs.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      want = sb.pop_front();
      got  = {bus.gnt_valid, bus.gnt, bus.gnt_idx, bus.timeout};
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%b gnt=%h idx=%0d to=%b, need v=%b gnt=%h idx=%0d to=%b",
                 n_mon, got.v, got.g, got.i, got.t,
                 want.v, want.g, want.i, want.t);
      end
      n_mon++;
    end
  end

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;

    // reset, then idle with no requests
    add(1, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // single requester 5, done on 3rd grant cycle
    add(0, 8'h20, 0, 1, 8'h20, 5, 0);
    add(0, 8'h20, 0, 1, 8'h20, 5, 0);
    add(0, 8'h20, 1, 0, 8'h00, 5, 0);
    // pointer now 6: 6 beats 5
    add(0, 8'h60, 0, 1, 8'h40, 6, 0);
    add(0, 8'h00, 0, 0, 8'h00, 6, 0);
    // rotation and wrap between 0 and 7
    add(1, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, 8'h81, 0, 1, 8'h01, 0, 0);
    add(0, 8'h81, 1, 0, 8'h00, 0, 0);
    add(0, 8'h81, 0, 1, 8'h80, 7, 0);
    add(0, 8'h81, 1, 0, 8'h00, 7, 0);
    add(0, 8'h81, 0, 1, 8'h01, 0, 0);
    add(0, 8'h81, 1, 0, 8'h00, 0, 0);
    add(0, 8'h81, 0, 1, 8'h80, 7, 0);
    add(0, 8'h81, 1, 0, 8'h00, 7, 0);
    // forced release after 4 cycles
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 0, 8'h00, 3, 1);
    // regrant; done at the limit is a normal release
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 1, 0, 8'h00, 3, 0);
    // done while idle is ignored
    add(0, 8'h00, 1, 0, 8'h00, 3, 0);
    // other req bits ignored; withdraw at limit
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h0F, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h08, 0, 1, 8'h08, 3, 0);
    add(0, 8'h00, 0, 0, 8'h00, 3, 0);
    // reset mid-grant of idx 6, then all request
    add(0, 8'h40, 0, 1, 8'h40, 6, 0);
    add(1, 8'h40, 0, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, 1, 8'h01, 0, 0);
    add(0, 8'hFF, 1, 0, 8'h00, 0, 0);
    add(0, 8'hFF, 0, 1, 8'h02, 1, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      #1;
      rst      = vecs[k].rst;
      bus.req  = vecs[k].req;
      bus.done = vecs[k].done;
      sb.push_back(vecs[k].want);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, need 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
